spi_axis_packer: RTL and testbench

Packs the byte stream from the LVDS SPI slave receiver (already in the `axi_clk` domain) into 32-bit little-endian words. Buffers the words in a small first-word-fall-through FIFO and presents them as an AXI4-Stream master without `tlast`. Sits directly upstream of `m_axis_tlast_gen`, which adds packet framing before the S2MM DMA. Reports overflow and dropped words to software.

---
 rtl/spi_pack_pkg.sv | 9 +
 rtl/axis_sync_fifo.sv | 46 ++++
 rtl/spi_axis_packer.sv | 127 ++++++++++++
 tb/tb_spi_axis_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pack_pkg.sv
// Shared widths and the byte-lane index type for the SPI byte-to-word packer.
package spi_pack_pkg;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int DROP_CNT_W = 16;

    typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible while not empty.
module axis_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_axis_packer.sv
// Packs SPI bytes into little-endian 32-bit AXI4-Stream words with overflow accounting.
// Optional partial-word idle flush is enabled by defining SPI_PACK_TIMEOUT_EN.
module spi_axis_packer
    import spi_pack_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          axi_clk,
    input  logic                          axi_rst,
    input  logic                          rx_dv,
    input  logic [BYTE_W-1:0]             rx_byte,
    input  logic                          frame_start,
    output logic [WORD_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [DROP_CNT_W-1:0]         drop_count
);
    localparam int HOLD_W = (WORD_BYTES - 1) * BYTE_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    lane_idx_t         idx_reg, idx_next, lane;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              word_push;
    logic [WORD_W-1:0] word_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic              timeout_flush;

`ifdef SPI_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_reg;

    assign timeout_flush = !rx_dv && !frame_start && (idx_reg != '0) &&
                           (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst)
            idle_reg <= '0;
        else if (rx_dv || frame_start || timeout_flush)
            idle_reg <= '0;
        else if (idx_reg != '0)
            idle_reg <= idle_reg + 1'b1;
    end
`else
    assign timeout_flush = 1'b0;
`endif

    // Lane 0 writes clear the upper lanes so a flushed partial word is zero-padded.
    always_comb begin
        lane      = frame_start ? lane_idx_t'(0) : idx_reg;
        idx_next  = lane;
        hold_next = hold_reg;
        word_push = 1'b0;
        word_data = {rx_byte, hold_reg};
        if (rx_dv) begin
            idx_next = lane + lane_idx_t'(1);
            case (lane)
                2'd0:    hold_next = {{(HOLD_W - BYTE_W){1'b0}}, rx_byte};
                2'd1:    hold_next[2*BYTE_W-1:BYTE_W] = rx_byte;
                2'd2:    hold_next[3*BYTE_W-1:2*BYTE_W] = rx_byte;
                default: word_push = 1'b1;
            endcase
        end else if (timeout_flush) begin
            word_push = 1'b1;
            word_data = {{BYTE_W{1'b0}}, hold_reg};
            idx_next  = '0;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            idx_reg  <= '0;
            hold_reg <= '0;
        end else begin
            idx_reg  <= idx_next;
            hold_reg <= hold_next;
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign pop  = m_axis_tvalid && m_axis_tready;
    assign drop = word_push && fifo_full && !pop;

    axis_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (axi_clk),
        .rst       (axi_rst),
        .push      (word_push),
        .push_data (word_data),
        .pop       (m_axis_tready),
        .pop_data  (m_axis_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A drop coincident with a clear restarts the count at one.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)
                drop_count <= DROP_CNT_W'(1);
            else if (drop_count != {DROP_CNT_W{1'b1}})
                drop_count <= drop_count + 1'b1;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_spi_axis_packer.sv
// Randomized self-checking bench for spi_axis_packer against a queue-based model.
module tb_spi_axis_packer;
    localparam int DEPTH = 16;
    localparam int TO    = 8;

    logic        axi_clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_start = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  byte_q [$];
    logic [31:0] word_q [$];
    logic        m_ovf = 1'b0;
    int          m_drop = 0;
    int          m_idle = 0;

    always #5 axi_clk = ~axi_clk;

    spi_axis_packer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_rst       (axi_rst),
        .rx_dv         (rx_dv),
        .rx_byte       (rx_byte),
        .frame_start   (frame_start),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .drop_count    (drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("tvalid", 32'(m_axis_tvalid), 32'(word_q.size() > 0));
        chk("tdata", m_axis_tdata, (word_q.size() > 0) ? word_q[0] : 32'h0);
        chk("fifo_level", 32'(fifo_level), 32'(word_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    // Reference behaviour: bytes gather in a list; four make a word, a word enters the queue if room.
    task automatic model_step(input logic dv, input logic [7:0] b, input logic fs,
                              input logic rdy, input logic clr);
        logic        pop, push, accept;
        logic [31:0] w;
        pop  = (word_q.size() > 0) && rdy;
        push = 1'b0;
        w    = 32'h0;
        if (fs) begin
            byte_q.delete();
            m_idle = 0;
        end
        if (dv) begin
            byte_q.push_back(b);
            m_idle = 0;
            if (byte_q.size() == 4) begin
                w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
                push = 1'b1;
                byte_q.delete();
            end
        end
`ifdef SPI_PACK_TIMEOUT_EN
        else if (!fs && byte_q.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                for (int i = 0; i < byte_q.size(); i++) w[8*i +: 8] = byte_q[i];
                push = 1'b1;
                byte_q.delete();
                m_idle = 0;
            end
        end
`endif
        accept = (word_q.size() < DEPTH) || pop;
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (pop) void'(word_q.pop_front());
        if (push) begin
            if (accept) word_q.push_back(w);
            else begin
                m_ovf  = 1'b1;
                m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            end
        end
    endtask

    task automatic cyc(input logic dv, input logic [7:0] b, input logic fs,
                       input logic rdy, input logic clr);
        rx_dv = dv;
        rx_byte = b;
        frame_start = fs;
        m_axis_tready = rdy;
        ovf_clr = clr;
        model_step(dv, b, fs, rdy, clr);
        @(posedge axi_clk);
        @(negedge axi_clk);
        compare_all();
        rx_dv = 1'b0;
        frame_start = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        rx_dv = 1'b0;
        frame_start = 1'b0;
        ovf_clr = 1'b0;
        axi_rst = 1'b1;
        #2;
        byte_q.delete();
        word_q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        m_idle = 0;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        @(posedge axi_clk);
        @(negedge axi_clk);
        axi_rst = 1'b0;
        compare_all();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (word_q.size() > 0 && guard < 200) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_bound", 32'(word_q.size()), 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        do_reset();

        // Single word, one-cycle valid with tready held high.
        cyc(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        chk("t1_not_yet", 32'(m_axis_tvalid), 32'h0);
        cyc(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        chk("t1_tdata", m_axis_tdata, 32'h44332211);
        chk("t1_tvalid", 32'(m_axis_tvalid), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t1_one_cycle", 32'(m_axis_tvalid), 32'h0);

        // Twenty words into a 16-deep FIFO with no consumer.
        for (int i = 0; i < 20; i++)
            for (int j = 0; j < 4; j++)
                cyc(1'b1, 8'(4*i + j), 1'b0, 1'b0, 1'b0);
        chk("t2_level", 32'(fifo_level), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'h1);
        chk("t2_drops", 32'(drop_count), 32'd4);
        chk("t2_head", m_axis_tdata, 32'h03020100);
        for (int k = 0; k < 60 && word_q.size() > 0; k++)
            cyc(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Frame start discards a partial word.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++) cyc(1'b1, 8'(j), 1'b0, 1'b0, 1'b0);
        chk("t3_tdata", m_axis_tdata, 32'h04030201);
        chk("t3_level", 32'(fifo_level), 32'h1);
        chk("t3_drops", 32'(drop_count), 32'h0);
        drain();

        // Frame start coincident with the first byte.
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
        chk("t4_tdata", m_axis_tdata, 32'h88776655);
        drain();

        // Full FIFO accepts when popping; then a clear coincident with a drop.
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) cyc(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0);
        chk("t5_level", 32'(fifo_level), 32'd16);
        chk("t5_no_ovf", 32'(overflow), 32'h0);
        chk("t5_no_drop", 32'(drop_count), 32'h0);
        for (int j = 0; j < 3; j++) cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hF3, 1'b0, 1'b0, 1'b1);
        chk("t5_clr_ovf", 32'(overflow), 32'h1);
        chk("t5_clr_drop", 32'(drop_count), 32'h1);
        drain();

        // Idle partial word: flushed only when the timeout feature is built in.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_early", 32'(m_axis_tvalid), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SPI_PACK_TIMEOUT_EN
        chk("t6_flush_valid", 32'(m_axis_tvalid), 32'h1);
        chk("t6_flush_data", m_axis_tdata, 32'h0000C2C1);
`else
        repeat (20) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_held", 32'(m_axis_tvalid), 32'h0);
`endif
        drain();
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Random traffic with varying backpressure and a mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            int rdy_pct;
            rdy_pct = ((n / 200) % 3 == 0) ? 10 : 75;
            if (n == 1500) begin
                do_reset();
                chk("rr_level", 32'(fifo_level), 32'h0);
            end
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom),
                1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 99) < rdy_pct),
                1'($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 9) == 0)
                repeat ($urandom_range(1, 12)) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
